// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART TX handshake bundle shared by the arbiter and its environment
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]   i_Req;
    logic [8*NUM_REQ-1:0] i_Req_Byte;
    logic [NUM_REQ-1:0]   i_Req_Last;
    logic [NUM_REQ-1:0]   o_Ack;
    logic [NUM_REQ-1:0]   o_Grant;
    logic                 o_Busy;
    logic                 o_Timeout;
    logic                 o_TX_DV;
    logic [7:0]           o_TX_Byte;
    logic                 i_TX_Active;
    logic                 i_TX_Done;
    modport master (
        input  i_Req, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
        output o_Ack, o_Grant, o_Busy, o_Timeout, o_TX_DV, o_TX_Byte
    );
    modport slave (
        output i_Req, i_Req_Byte, i_Req_Last, i_TX_Active, i_TX_Done,
        input  o_Ack, o_Grant, o_Busy, o_Timeout, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART TX, with a done-handshake watchdog
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int TIMEOUT_CLKS = 2604
) (
    input logic               i_Clock,
    input logic               i_Reset,
    uart_tx_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CLKS);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, g_q, g_d, pick, idx, g_next;
    logic               pick_ok, release_now;
    logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
    logic [7:0]         burst_q, burst_d, byte_q, byte_d;
    logic [WW-1:0]      wd_q, wd_d;
    logic               last_q, last_d, dv_q, dv_d, to_q, to_d;

    // Scan downward so the requester closest above the pointer is the last to overwrite pick.
    always_comb begin
        pick = ptr_q;
        idx = ptr_q;
        pick_ok = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (bus.i_Req[idx]) begin
                pick = idx;
                pick_ok = 1'b1;
            end
        end
    end

    assign g_next      = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
    assign release_now = last_q || burst_q == 8'(MAX_BURST) || !bus.i_Req[g_q];

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        g_d = g_q;
        grant_d = grant_q;
        burst_d = burst_q;
        byte_d = byte_q;
        wd_d = wd_q;
        last_d = last_q;
        dv_d = 1'b0;
        ack_d = '0;
        to_d = 1'b0;
        case (state_q)
            IDLE: if (pick_ok) begin
                g_d = pick;
                grant_d = NUM_REQ'(1) << pick;
                burst_d = '0;
                state_d = LOAD;
            end
            LOAD: if (!bus.i_Req[g_q]) begin
                grant_d = '0;
                ptr_d = g_next;
                state_d = IDLE;
            end else if (!bus.i_TX_Active) begin
                byte_d = bus.i_Req_Byte[{g_q, 3'b000} +: 8];
                last_d = bus.i_Req_Last[g_q];
                dv_d = 1'b1;
                ack_d = grant_q;
                burst_d = (burst_q == 8'(MAX_BURST)) ? burst_q : burst_q + 8'd1;
                wd_d = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                wd_d = wd_q + 1'b1;
                // A done arriving on the expiry cycle takes priority over the watchdog.
                to_d = !bus.i_TX_Done && wd_q == WW'(TIMEOUT_CLKS - 1);
                if (to_d || (bus.i_TX_Done && release_now)) begin
                    grant_d = '0;
                    ptr_d = g_next;
                    state_d = IDLE;
                end else if (bus.i_TX_Done) begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            ptr_q <= '0;
            g_q <= '0;
            grant_q <= '0;
            burst_q <= '0;
            byte_q <= '0;
            wd_q <= '0;
            last_q <= 1'b0;
            dv_q <= 1'b0;
            ack_q <= '0;
            to_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            g_q <= g_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            byte_q <= byte_d;
            wd_q <= wd_d;
            last_q <= last_d;
            dv_q <= dv_d;
            ack_q <= ack_d;
            to_q <= to_d;
        end
    end

    assign bus.o_Grant   = grant_q;
    assign bus.o_Ack     = ack_q;
    assign bus.o_Busy    = state_q != IDLE;
    assign bus.o_Timeout = to_q;
    assign bus.o_TX_DV   = dv_q;
    assign bus.o_TX_Byte = byte_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with per-requester byte sources, a UART TX model and a serial decoder
module tb_uart_tx_arbiter;
    localparam int N = 4, MB = 16, TO = 2604;

    typedef struct { int r; logic [7:0] b; } ex_t;
    typedef logic [8:0] bq_t[$];

    logic clk = 1'b0, rst = 1'b1;
    logic act_m = 1'b0, act_f = 1'b0, done_m = 1'b0, line = 1'b1, tx_hang = 1'b0;
    int   bit_clks = 217, tests = 0, fails = 0, to_cnt = 0;
    ex_t  exp_q[$];
    logic [7:0] ser_q[$];
    bq_t  src_q[N];

    always #20 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
    assign bus.i_TX_Active = act_m | act_f;
    assign bus.i_TX_Done   = done_m;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .TIMEOUT_CLKS(TO)) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h, expected nothing", name, act);
    endtask

    task automatic src(input int r, input logic [7:0] b, input logic last);
        src_q[r].push_back({last, b});
    endtask

    task automatic expect_tx(input int r, input logic [7:0] b);
        exp_q.push_back('{r, b});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        foreach (src_q[n]) src_q[n].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int i = 0;
        while ((exp_q.size() != 0 || bus.o_Busy || act_m) && i < 60000) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 0);
        chk({name, "_busy"}, 32'(bus.o_Busy), 0);
    endtask

    // Byte sources: hold each byte until its ack, then present the next one.
    initial begin
        logic [N-1:0]   ack_s, req, last;
        logic [8*N-1:0] bytes;
        bus.i_Req = '0;
        bus.i_Req_Byte = '0;
        bus.i_Req_Last = '0;
        forever begin
            @(posedge clk);
            ack_s = bus.o_Ack;
            #1;
            for (int n = 0; n < N; n++) begin
                if (ack_s[n] && src_q[n].size() != 0) void'(src_q[n].pop_front());
                req[n] = src_q[n].size() != 0;
                bytes[8*n +: 8] = 8'h00;
                last[n] = 1'b0;
                if (req[n]) begin
                    bytes[8*n +: 8] = src_q[n][0][7:0];
                    last[n] = src_q[n][0][8];
                end
            end
            bus.i_Req = req;
            bus.i_Req_Byte = bytes;
            bus.i_Req_Last = last;
        end
    end

    // UART TX model: 8N1 frame of bit_clks per bit, done pulse unless hung.
    initial forever begin
        @(posedge clk);
        if (bus.o_TX_DV) begin
            logic [9:0] frame;
            frame = {1'b1, bus.o_TX_Byte, 1'b0};
            #1 act_m = 1'b1;
            for (int k = 0; k < 10; k++) begin
                line = frame[k];
                repeat (bit_clks) @(posedge clk);
                #1;
            end
            line = 1'b1;
            act_m = 1'b0;
            done_m = !tx_hang;
            @(posedge clk);
            #1 done_m = 1'b0;
        end
    end

    // Serial decoder: samples mid-bit and checks against bytes seen at o_TX_DV.
    initial forever begin
        @(negedge clk);
        if (!line) begin
            logic [7:0] rx;
            repeat (bit_clks / 2) @(negedge clk);
            chk("rx_start", 32'(line), 0);
            for (int k = 0; k < 8; k++) begin
                repeat (bit_clks) @(negedge clk);
                rx[k] = line;
            end
            repeat (bit_clks) @(negedge clk);
            chk("rx_stop", 32'(line), 1);
            if (ser_q.size() == 0) flag("rx_unexpected", 32'(rx));
            else chk("rx_byte", 32'(rx), 32'(ser_q.pop_front()));
        end
    end

    // Scoreboard monitor.
    initial forever begin
        @(negedge clk);
        if (bus.o_Timeout) to_cnt++;
        if (bus.o_Ack != '0) chk("ack_with_dv", 32'(bus.o_TX_DV), 1);
        if (bus.o_TX_DV) begin
            ex_t e;
            ser_q.push_back(bus.o_TX_Byte);
            if (exp_q.size() == 0) flag("dv_unexpected", 32'(bus.o_TX_Byte));
            else begin
                e = exp_q.pop_front();
                chk("tx_byte", 32'(bus.o_TX_Byte), 32'(e.b));
                chk("ack_owner", 32'(bus.o_Ack), 32'(1 << e.r));
                chk("grant_owner", 32'(bus.o_Grant), 32'(1 << e.r));
            end
        end
    end

    initial begin
        int cnt, dvs;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(bus.o_Grant), 0);
        chk("rst_ack", 32'(bus.o_Ack), 0);
        chk("rst_busy", 32'(bus.o_Busy), 0);
        chk("rst_timeout", 32'(bus.o_Timeout), 0);
        chk("rst_dv", 32'(bus.o_TX_DV), 0);
        chk("rst_byte", 32'(bus.o_TX_Byte), 0);
        rst = 1'b0;

        // single byte at full bit time
        src(0, 8'h37, 1'b1);
        expect_tx(0, 8'h37);
        @(posedge clk);
        @(negedge clk);
        chk("t1_grant_c0", 32'(bus.o_Grant), 0);
        @(negedge clk);
        chk("t1_grant_c1", 32'(bus.o_Grant), 4'b0001);
        chk("t1_dv_c1", 32'(bus.o_TX_DV), 0);
        @(negedge clk);
        chk("t1_dv_c2", 32'(bus.o_TX_DV), 1);
        chk("t1_ack_c2", 32'(bus.o_Ack), 4'b0001);
        for (int i = 0; i < 3000 && !bus.i_TX_Done; i++) @(negedge clk);
        chk("t1_done_seen", 32'(bus.i_TX_Done), 1);
        chk("t1_busy_at_done", 32'(bus.o_Busy), 1);
        @(negedge clk);
        chk("t1_busy_after", 32'(bus.o_Busy), 0);
        chk("t1_grant_after", 32'(bus.o_Grant), 0);
        drain("t1");
        bit_clks = 8;

        // round robin
        do_reset();
        src(0, 8'hA0, 1'b1); src(0, 8'hA0, 1'b1); src(1, 8'hA1, 1'b1); src(3, 8'hA3, 1'b1);
        expect_tx(0, 8'hA0); expect_tx(1, 8'hA1); expect_tx(3, 8'hA3); expect_tx(0, 8'hA0);
        drain("rr");

        // burst cap with a competing requester
        do_reset();
        for (int i = 0; i < 20; i++) src(2, 8'(i), 1'b0);
        for (int i = 0; i < 16; i++) expect_tx(2, 8'(i));
        expect_tx(1, 8'hB1);
        for (int i = 16; i < 20; i++) expect_tx(2, 8'(i));
        for (int i = 0; i < 10 && bus.o_Grant != 4'b0100; i++) @(negedge clk);
        chk("burst_grant2", 32'(bus.o_Grant), 4'b0100);
        src(1, 8'hB1, 1'b1);
        drain("burst");

        // last flag forces release
        do_reset();
        src(0, 8'h11, 1'b0); src(0, 8'h22, 1'b1); src(0, 8'h33, 1'b1); src(1, 8'hB1, 1'b1);
        expect_tx(0, 8'h11); expect_tx(0, 8'h22); expect_tx(1, 8'hB1); expect_tx(0, 8'h33);
        drain("last");

        // watchdog
        do_reset();
        tx_hang = 1'b1;
        src(0, 8'h5A, 1'b1); src(1, 8'h5B, 1'b1);
        expect_tx(0, 8'h5A); expect_tx(1, 8'h5B);
        for (int i = 0; i < 10 && !bus.o_TX_DV; i++) @(negedge clk);
        chk("wd_dv_seen", 32'(bus.o_TX_DV), 1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!bus.o_Timeout && cnt < 3000);
        tx_hang = 1'b0;
        chk("wd_latency", 32'(cnt), TO);
        chk("wd_idle_at_timeout", 32'(bus.o_Busy), 0);
        @(negedge clk);
        chk("wd_pulse_width", 32'(bus.o_Timeout), 0);
        drain("wd");

        // reset mid-frame with the TX held active
        do_reset();
        src(0, 8'hC0, 1'b1);
        expect_tx(0, 8'hC0);
        for (int i = 0; i < 10 && !bus.o_TX_DV; i++) @(negedge clk);
        chk("mid_dv_seen", 32'(bus.o_TX_DV), 1);
        repeat (36) @(negedge clk);
        act_f = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(bus.o_Grant), 0);
        chk("mid_rst_busy", 32'(bus.o_Busy), 0);
        chk("mid_rst_byte", 32'(bus.o_TX_Byte), 0);
        @(negedge clk);
        rst = 1'b0;
        src(2, 8'hC2, 1'b1);
        expect_tx(2, 8'hC2);
        repeat (3) @(negedge clk);
        chk("mid_grant2", 32'(bus.o_Grant), 4'b0100);
        dvs = 0;
        repeat (495) begin
            @(negedge clk);
            dvs += int'(bus.o_TX_DV);
        end
        chk("mid_stall_no_dv", 32'(dvs), 0);
        chk("mid_stall_grant", 32'(bus.o_Grant), 4'b0100);
        act_f = 1'b0;
        for (int i = 0; i < 10 && !bus.o_TX_DV; i++) @(negedge clk);
        chk("mid_dv_after_idle", 32'(bus.o_TX_DV), 1);
        drain("mid");

        repeat (5) @(negedge clk);
        chk("timeout_count", 32'(to_cnt), 1);
        chk("rx_all_decoded", 32'(ser_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
